// File: rtl/uart_tx_fifo_feeder.sv
// uart_tx_fifo_feeder
//   Buffers producer bytes in a DEPTH-entry synchronous FIFO. Bytes are handed one at a
//   time to the UART TX frame controller, and the feeder waits for each frame to finish
//   before it sends the next byte.
// Ports:
//   CLK, RST    clock (rising edge), asynchronous active-low reset
//   WR_DATA     producer byte
//   WR_EN       producer write strobe
//   FULL        FIFO holds DEPTH entries (registered)
//   EMPTY       FIFO holds no entries (registered)
//   COUNT       FIFO occupancy (registered)
//   OVF_ERR     1-cycle pulse: a write was dropped because the FIFO was full
//   TMO_ERR     1-cycle pulse: TX busy never rose after a launch
//   P_DATA      byte presented to the TX, held until the next launch
//   Data_valid  1-cycle launch strobe to the TX
//   busy        TX busy flag
module uart_tx_fifo_feeder #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned BUSY_TIMEOUT = 15
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     WR_DATA,
    input  logic                      WR_EN,
    output logic                      FULL,
    output logic                      EMPTY,
    output logic [$clog2(DEPTH):0]    COUNT,
    output logic                      OVF_ERR,
    output logic                      TMO_ERR,
    output logic [DATA_WIDTH-1:0]     P_DATA,
    output logic                      Data_valid,
    input  logic                      busy
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned TmoW = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(DEPTH);
    localparam logic [TmoW-1:0] TmoLast = TmoW'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StWaitDone
    } state_e;

    state_e                state_q, state_d;
    logic [TmoW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                  tmo_d;
    logic                  load_pdata;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]       count_q, count_d;
    logic                  full_q, empty_q;
    logic                  ovf_q, tmo_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  wr_accept;
    logic                  pop;

    // A write while full is dropped even if a pop frees a slot in the same cycle.
    assign wr_accept = WR_EN && !full_q;
    // The launched byte leaves the FIFO at the end of the launch cycle.
    assign pop       = (state_q == StLaunch);

    always_comb begin
        count_d = count_q;
        if (wr_accept && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!wr_accept && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage carries no reset: entries are meaningless once the pointers are cleared.
    always_ff @(posedge CLK) begin
        if (wr_accept) begin
            mem[wr_ptr_q] <= WR_DATA;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            count_q <= count_d;
            full_q  <= (count_d == FullCnt);
            empty_q <= (count_d == '0);
            ovf_q   <= WR_EN && full_q;
        end
    end

    always_comb begin
        state_d    = state_q;
        tmo_cnt_d  = tmo_cnt_q;
        tmo_d      = 1'b0;
        load_pdata = 1'b0;
        unique case (state_q)
            StIdle: begin
                // Busy high here belongs to someone else's frame; hold off until it clears.
                if (!empty_q && !busy) begin
                    state_d    = StLaunch;
                    load_pdata = 1'b1;
                end
            end
            StLaunch: begin
                state_d   = StWaitBusy;
                tmo_cnt_d = '0;
            end
            StWaitBusy: begin
                // The TX keeps busy low through its start-bit state, so low is not "done".
                if (busy) begin
                    state_d = StWaitDone;
                end else if (tmo_cnt_q == TmoLast) begin
                    state_d = StIdle;
                    tmo_d   = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            StWaitDone: begin
                if (!busy) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q   <= StIdle;
            tmo_cnt_q <= '0;
            tmo_q     <= 1'b0;
            p_data_q  <= '0;
        end else begin
            state_q   <= state_d;
            tmo_cnt_q <= tmo_cnt_d;
            tmo_q     <= tmo_d;
            if (load_pdata) begin
                p_data_q <= mem[rd_ptr_q];
            end
        end
    end

    assign FULL       = full_q;
    assign EMPTY      = empty_q;
    assign COUNT      = count_q;
    assign OVF_ERR    = ovf_q;
    assign TMO_ERR    = tmo_q;
    assign P_DATA     = p_data_q;
    assign Data_valid = (state_q == StLaunch);

endmodule

// File: tb/tb_uart_tx_fifo_feeder.sv
// Self-checking bench for uart_tx_fifo_feeder: directed stimulus, a queue-based model
// compared every cycle, and literal timing/data expectations.
module tb_uart_tx_fifo_feeder;

    localparam int DEPTH = 8;
    localparam int TMO   = 15;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] WR_DATA;
    logic       WR_EN;
    logic       FULL, EMPTY;
    logic [3:0] COUNT;
    logic       OVF_ERR, TMO_ERR;
    logic [7:0] P_DATA;
    logic       Data_valid;
    logic       busy_line;

    logic       tx_auto;
    logic       busy_force;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_dv = -100;

    int         dv_cycles[$];
    int         tmo_cycles[$];
    logic [7:0] launched[$];

    // Model state
    logic [7:0] q[$];
    bit         m_idle, m_dv, m_frame, m_ovf, m_tmo;
    int         m_since;
    logic [7:0] m_pdata;

    uart_tx_fifo_feeder #(
        .DATA_WIDTH  (8),
        .DEPTH       (DEPTH),
        .BUSY_TIMEOUT(TMO)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .WR_DATA   (WR_DATA),
        .WR_EN     (WR_EN),
        .FULL      (FULL),
        .EMPTY     (EMPTY),
        .COUNT     (COUNT),
        .OVF_ERR   (OVF_ERR),
        .TMO_ERR   (TMO_ERR),
        .P_DATA    (P_DATA),
        .Data_valid(Data_valid),
        .busy      (busy_line)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_idle  = 1'b1;
        m_dv    = 1'b0;
        m_frame = 1'b0;
        m_ovf   = 1'b0;
        m_tmo   = 1'b0;
        m_since = 0;
        m_pdata = 8'h00;
    endtask

    // One clock edge of the feeder, from its rules: queue occupancy, launch when idle with
    // data and TX free, give up TMO cycles after the launch if busy never appears.
    task automatic model_step();
        bit full_now;
        bit accept;
        bit pop;
        full_now = (q.size() == DEPTH);
        accept   = WR_EN && !full_now;
        pop      = m_dv;
        m_ovf    = WR_EN && full_now;
        m_tmo    = 1'b0;
        if (m_idle) begin
            if (q.size() != 0 && !busy_line) begin
                m_idle  = 1'b0;
                m_dv    = 1'b1;
                m_pdata = q[0];
            end
        end else if (m_dv) begin
            m_dv    = 1'b0;
            m_since = 1;
            m_frame = 1'b0;
        end else if (!m_frame) begin
            if (busy_line) begin
                m_frame = 1'b1;
            end else if (m_since == TMO) begin
                m_idle = 1'b1;
                m_tmo  = 1'b1;
            end else begin
                m_since++;
            end
        end else if (!busy_line) begin
            m_idle = 1'b1;
        end
        if (pop) void'(q.pop_front());
        if (accept) q.push_back(WR_DATA);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge CLK or negedge RST);
            if (!RST) model_reset();
            else model_step();
        end
    end

    // Per-cycle compare plus launch/timeout bookkeeping.
    initial begin
        forever begin
            @(negedge CLK);
            check("outputs",
                  32'({FULL, EMPTY, COUNT, OVF_ERR, TMO_ERR, P_DATA, Data_valid}),
                  32'({(q.size() == DEPTH), (q.size() == 0), 4'(q.size()), m_ovf, m_tmo,
                       m_pdata, m_dv}));
            if (Data_valid === 1'b1) begin
                dv_cycles.push_back(cyc);
                launched.push_back(P_DATA);
                last_dv = cyc;
            end
            if (TMO_ERR === 1'b1) tmo_cycles.push_back(cyc);
        end
    end

    // TX model: busy high from 2 to 11 cycles after each Data_valid, or forced.
    initial begin
        busy_line = 1'b0;
        forever begin
            @(posedge CLK);
            #2;
            if (tx_auto) busy_line = (cyc >= last_dv + 2) && (cyc <= last_dv + 11);
            else busy_line = busy_force;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_byte(input logic [7:0] d);
        WR_EN   = 1'b1;
        WR_DATA = d;
        tick();
        WR_EN   = 1'b0;
    endtask

    task automatic wait_launches(input int n, input int bound);
        int k = 0;
        while (dv_cycles.size() < n && k < bound) begin
            tick();
            k++;
        end
        check("launch_wait", 32'(dv_cycles.size() >= n), 32'd1);
    endtask

    task automatic drain();
        int k = 0;
        while (EMPTY !== 1'b1 && k < 2000) begin
            tick();
            k++;
        end
        check("drain_empty", 32'(EMPTY), 32'd1);
        repeat (16) tick();
    endtask

    initial begin
        int n0;
        int t0;
        int wc;
        int rel;
        int i;
        int k;
        RST        = 1'b0;
        WR_EN      = 1'b0;
        WR_DATA    = 8'h00;
        tx_auto    = 1'b0;
        busy_force = 1'b0;

        // Reset values
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset_count", 32'(COUNT), 32'd0);
        check("reset_flags", 32'({FULL, EMPTY, OVF_ERR, TMO_ERR, Data_valid}), 32'b01000);
        check("reset_pdata", 32'(P_DATA), 32'h00);
        tick();
        RST = 1'b1;

        // Single byte
        tx_auto = 1'b1;
        tick();
        tick();
        n0 = dv_cycles.size();
        wc = cyc;
        write_byte(8'hA5);
        @(negedge CLK);
        check("single_empty_n1", 32'(EMPTY), 32'd0);
        wait_launches(n0 + 1, 20);
        check("single_latency", 32'(dv_cycles[n0]), 32'(wc + 2));
        check("single_data", 32'(launched[n0]), 32'hA5);
        repeat (30) tick();
        check("single_one_pulse", 32'(dv_cycles.size()), 32'(n0 + 1));

        // Burst of 8 held back by a foreign frame, then released
        tx_auto    = 1'b0;
        busy_force = 1'b1;
        tick();
        n0 = dv_cycles.size();
        for (int b = 1; b <= 8; b++) write_byte(8'(b));
        @(negedge CLK);
        check("burst_full", 32'(FULL), 32'd1);
        check("burst_count", 32'(COUNT), 32'd8);
        tick();
        check("busy_blocks_launch", 32'(dv_cycles.size()), 32'(n0));
        tx_auto = 1'b1;
        rel = cyc;
        wait_launches(n0 + 8, 300);
        check("release_latency", 32'(dv_cycles[n0]), 32'(rel + 1));
        for (int b = 0; b < 8; b++) check("burst_order", 32'(launched[n0 + b]), 32'(b + 1));
        for (int b = 1; b < 8; b++)
            check("b2b_gap", 32'(dv_cycles[n0 + b] - dv_cycles[n0 + b - 1]), 32'd14);
        drain();

        // Overflow
        tx_auto    = 1'b0;
        busy_force = 1'b1;
        tick();
        n0 = dv_cycles.size();
        for (int b = 0; b < 8; b++) write_byte(8'h11 + 8'(b));
        WR_EN   = 1'b1;
        WR_DATA = 8'h19;
        tick();
        WR_EN = 1'b0;
        @(negedge CLK);
        check("ovf_pulse", 32'(OVF_ERR), 32'd1);
        check("ovf_count", 32'(COUNT), 32'd8);
        tick();
        @(negedge CLK);
        check("ovf_one_cycle", 32'(OVF_ERR), 32'd0);
        tick();
        tx_auto = 1'b1;
        wait_launches(n0 + 8, 300);
        for (int b = 0; b < 8; b++) check("ovf_order", 32'(launched[n0 + b]), 32'(8'h11 + b));
        drain();
        check("ovf_dropped", 32'(dv_cycles.size()), 32'(n0 + 8));

        // Timeout: busy stuck low
        tx_auto    = 1'b0;
        busy_force = 1'b0;
        tick();
        n0 = dv_cycles.size();
        t0 = tmo_cycles.size();
        wc = cyc;
        write_byte(8'hA1);
        write_byte(8'hA2);
        wait_launches(n0 + 2, 100);
        repeat (20) tick();
        check("tmo_first_launch", 32'(dv_cycles[n0]), 32'(wc + 2));
        check("tmo_delay", 32'(tmo_cycles[t0]), 32'(dv_cycles[n0] + 1 + TMO));
        check("tmo_next_launch", 32'(dv_cycles[n0 + 1]), 32'(tmo_cycles[t0] + 1));
        check("tmo_pulses", 32'(tmo_cycles.size()), 32'(t0 + 2));
        check("tmo_data", 32'({launched[n0], launched[n0 + 1]}), 32'h0000A1A2);

        // Write during launch with three entries queued
        busy_force = 1'b1;
        tick();
        n0 = dv_cycles.size();
        write_byte(8'h31);
        write_byte(8'h32);
        write_byte(8'h33);
        @(negedge CLK);
        check("sim_count_before", 32'(COUNT), 32'd3);
        tick();
        tx_auto = 1'b1;
        tick();
        WR_EN   = 1'b1;
        WR_DATA = 8'h34;
        @(negedge CLK);
        check("sim_launch", 32'(Data_valid), 32'd1);
        check("sim_count_launch", 32'(COUNT), 32'd3);
        tick();
        WR_EN = 1'b0;
        @(negedge CLK);
        check("sim_count_after", 32'(COUNT), 32'd3);
        wait_launches(n0 + 4, 200);
        for (int b = 0; b < 4; b++) check("sim_order", 32'(launched[n0 + b]), 32'(8'h31 + b));
        drain();

        // Pointer wrap over 3*DEPTH bytes
        n0 = dv_cycles.size();
        i = 0;
        k = 0;
        while (i < 3 * DEPTH && k < 3000) begin
            if (FULL !== 1'b1) begin
                WR_EN   = 1'b1;
                WR_DATA = 8'h40 + 8'(i);
                i++;
            end else begin
                WR_EN = 1'b0;
            end
            tick();
            k++;
        end
        WR_EN = 1'b0;
        wait_launches(n0 + 3 * DEPTH, 800);
        for (int b = 0; b < 3 * DEPTH; b++)
            check("wrap_order", 32'(launched[n0 + b]), 32'(8'h40 + b));
        drain();

        // Reset mid-frame
        tx_auto = 1'b1;
        tick();
        n0 = dv_cycles.size();
        write_byte(8'h51);
        write_byte(8'h52);
        wait_launches(n0 + 1, 20);
        repeat (4) tick();
        #2;
        RST = 1'b0;
        #1;
        check("midrst_count", 32'(COUNT), 32'd0);
        check("midrst_flags", 32'({FULL, EMPTY, OVF_ERR, TMO_ERR, Data_valid}), 32'b01000);
        check("midrst_pdata", 32'(P_DATA), 32'h00);
        tx_auto    = 1'b0;
        busy_force = 1'b0;
        tick();
        tick();
        RST = 1'b1;
        repeat (20) tick();
        check("postrst_empty", 32'(EMPTY), 32'd1);
        check("postrst_count", 32'(COUNT), 32'd0);
        check("postrst_no_launch", 32'(dv_cycles.size()), 32'(n0 + 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
